// File: rtl/issue_queue_ooo.sv
// Collapsing out-of-order issue queue: slot 0 is oldest, sources wake from NUM_WB tag buses, oldest ready entry issues.
// Optional macro IQ_SELECT_BYPASS_EN: a same-cycle wakeup also makes an entry eligible for select.
module issue_queue_ooo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int TAG_WIDTH  = 6,
    parameter int NUM_WB     = 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        flush,
    input  logic                        enq_valid,
    output logic                        enq_ready,
    input  logic [DATA_WIDTH-1:0]       enq_data,
    input  logic [TAG_WIDTH-1:0]        enq_src1_tag,
    input  logic                        enq_src1_rdy,
    input  logic [TAG_WIDTH-1:0]        enq_src2_tag,
    input  logic                        enq_src2_rdy,
    input  logic [TAG_WIDTH-1:0]        enq_dst_tag,
    input  logic [NUM_WB-1:0]           wb_valid,
    input  logic [NUM_WB*TAG_WIDTH-1:0] wb_tag,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output logic [DATA_WIDTH-1:0]       iss_data,
    output logic [TAG_WIDTH-1:0]        iss_dst_tag,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      s1_rdy_q, s1_rdy_d;
    logic [DEPTH-1:0]      s2_rdy_q, s2_rdy_d;
    logic [DATA_WIDTH-1:0] data_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_d   [DEPTH];
    logic [TAG_WIDTH-1:0]  s1_tag_q [DEPTH];
    logic [TAG_WIDTH-1:0]  s1_tag_d [DEPTH];
    logic [TAG_WIDTH-1:0]  s2_tag_q [DEPTH];
    logic [TAG_WIDTH-1:0]  s2_tag_d [DEPTH];
    logic [TAG_WIDTH-1:0]  dst_tag_q[DEPTH];
    logic [TAG_WIDTH-1:0]  dst_tag_d[DEPTH];
    logic [CW-1:0]         count_q, count_d;

    logic [DEPTH-1:0] s1_ok, s2_ok, elig;
    logic [IW-1:0]    sel_idx;
    logic             iss_fire, enq_fire;
    logic [CW-1:0]    wr_ptr;

    function automatic logic tag_hit(input logic [NUM_WB-1:0]           v,
                                     input logic [NUM_WB*TAG_WIDTH-1:0] tags,
                                     input logic [TAG_WIDTH-1:0]        t);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (v[k] && (tags[k*TAG_WIDTH +: TAG_WIDTH] == t)) hit = 1'b1;
        end
        return hit;
    endfunction

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elig
`ifdef IQ_SELECT_BYPASS_EN
            assign s1_ok[gi] = s1_rdy_q[gi] | tag_hit(wb_valid, wb_tag, s1_tag_q[gi]);
            assign s2_ok[gi] = s2_rdy_q[gi] | tag_hit(wb_valid, wb_tag, s2_tag_q[gi]);
`else
            assign s1_ok[gi] = s1_rdy_q[gi];
            assign s2_ok[gi] = s2_rdy_q[gi];
`endif
            assign elig[gi] = valid_q[gi] & s1_ok[gi] & s2_ok[gi];
        end
    endgenerate

    // Scanning downward leaves the lowest (oldest) eligible slot selected.
    always_comb begin
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig[i]) sel_idx = IW'(i);
        end
    end

    assign count       = count_q;
    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign enq_ready   = ~full;
    assign enq_fire    = enq_valid & enq_ready;
    assign iss_valid   = |elig;
    assign iss_fire    = iss_valid & iss_ready;
    assign iss_data    = iss_valid ? data_q[sel_idx]    : '0;
    assign iss_dst_tag = iss_valid ? dst_tag_q[sel_idx] : '0;
    assign wr_ptr      = count_q - {{(CW-1){1'b0}}, iss_fire};

    always_comb begin
        valid_d   = valid_q;
        s1_rdy_d  = s1_rdy_q;
        s2_rdy_d  = s2_rdy_q;
        data_d    = data_q;
        s1_tag_d  = s1_tag_q;
        s2_tag_d  = s2_tag_q;
        dst_tag_d = dst_tag_q;

        if (iss_fire) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(sel_idx)) begin
                    valid_d[i]   = valid_q[i+1];
                    s1_rdy_d[i]  = s1_rdy_q[i+1];
                    s2_rdy_d[i]  = s2_rdy_q[i+1];
                    data_d[i]    = data_q[i+1];
                    s1_tag_d[i]  = s1_tag_q[i+1];
                    s2_tag_d[i]  = s2_tag_q[i+1];
                    dst_tag_d[i] = dst_tag_q[i+1];
                end
            end
            valid_d[DEPTH-1]   = 1'b0;
            s1_rdy_d[DEPTH-1]  = 1'b0;
            s2_rdy_d[DEPTH-1]  = 1'b0;
            data_d[DEPTH-1]    = '0;
            s1_tag_d[DEPTH-1]  = '0;
            s2_tag_d[DEPTH-1]  = '0;
            dst_tag_d[DEPTH-1] = '0;
        end

        if (enq_fire) begin
            valid_d[wr_ptr[IW-1:0]]   = 1'b1;
            s1_rdy_d[wr_ptr[IW-1:0]]  = enq_src1_rdy;
            s2_rdy_d[wr_ptr[IW-1:0]]  = enq_src2_rdy;
            data_d[wr_ptr[IW-1:0]]    = enq_data;
            s1_tag_d[wr_ptr[IW-1:0]]  = enq_src1_tag;
            s2_tag_d[wr_ptr[IW-1:0]]  = enq_src2_tag;
            dst_tag_d[wr_ptr[IW-1:0]] = enq_dst_tag;
        end

        // Wakeup on post-shift contents, including the entry written this cycle.
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_d[i]) begin
                s1_rdy_d[i] = s1_rdy_d[i] | tag_hit(wb_valid, wb_tag, s1_tag_d[i]);
                s2_rdy_d[i] = s2_rdy_d[i] | tag_hit(wb_valid, wb_tag, s2_tag_d[i]);
            end
        end

        count_d = count_q + {{(CW-1){1'b0}}, enq_fire} - {{(CW-1){1'b0}}, iss_fire};
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            valid_q  <= '0;
            s1_rdy_q <= '0;
            s2_rdy_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            s1_rdy_q <= s1_rdy_d;
            s2_rdy_q <= s2_rdy_d;
            count_q  <= count_d;
        end
    end

    // Payload fields need no reset: they are only observed behind valid bits.
    always_ff @(posedge clk) begin
        data_q    <= data_d;
        s1_tag_q  <= s1_tag_d;
        s2_tag_q  <= s2_tag_d;
        dst_tag_q <= dst_tag_d;
    end
endmodule

// File: tb/tb_issue_queue_ooo.sv
// Scoreboard bench for issue_queue_ooo: an age-ordered queue model predicts issues, a negedge monitor checks them.
module tb_issue_queue_ooo;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int TW    = 6;
    localparam int NWB   = 2;

    logic              clk = 1'b0;
    logic              resetn, flush, enq_valid, enq_ready;
    logic [DW-1:0]     enq_data;
    logic [TW-1:0]     enq_src1_tag, enq_src2_tag, enq_dst_tag;
    logic              enq_src1_rdy, enq_src2_rdy;
    logic [NWB-1:0]    wb_valid;
    logic [NWB*TW-1:0] wb_tag;
    logic              iss_valid, iss_ready;
    logic [DW-1:0]     iss_data;
    logic [TW-1:0]     iss_dst_tag;
    logic [4:0]        count;
    logic              full, empty;

    always #5 clk = ~clk;

    issue_queue_ooo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TAG_WIDTH(TW), .NUM_WB(NWB)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
        .enq_src1_tag(enq_src1_tag), .enq_src1_rdy(enq_src1_rdy),
        .enq_src2_tag(enq_src2_tag), .enq_src2_rdy(enq_src2_rdy),
        .enq_dst_tag(enq_dst_tag), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_data(iss_data),
        .iss_dst_tag(iss_dst_tag), .count(count), .full(full), .empty(empty)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] s1t;
        logic          s1r;
        logic [TW-1:0] s2t;
        logic          s2r;
        logic [TW-1:0] dst;
    } ent_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] dst;
    } iss_t;

    ent_t mq[$];     // model contents, oldest first
    iss_t exp_q[$];  // expected issues in order
    iss_t got;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit wb_hit(input logic [TW-1:0] t);
        bit h;
        h = 1'b0;
        for (int k = 0; k < NWB; k++)
            if (wb_valid[k] && wb_tag[k*TW +: TW] == t) h = 1'b1;
        return h;
    endfunction

    function automatic bit eligible(input ent_t e);
`ifdef IQ_SELECT_BYPASS_EN
        return (e.s1r || wb_hit(e.s1t)) && (e.s2r || wb_hit(e.s2t));
`else
        return e.s1r && e.s2r;
`endif
    endfunction

    // Monitor: every observed handshake must match the next expected issue.
    always @(negedge clk) begin
        if (resetn === 1'b1 && iss_valid === 1'b1 && iss_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got data %0h dst %0h expected no issue", iss_data, iss_dst_tag);
            end else begin
                got = exp_q.pop_front();
                chk("iss_data", 64'(iss_data), 64'(got.data));
                chk("iss_dst_tag", 64'(iss_dst_tag), 64'(got.dst));
            end
        end
    end

    task automatic do_reset();
        resetn = 1'b0; flush = 1'b0; enq_valid = 1'b0; iss_ready = 1'b0;
        enq_data = '0; enq_src1_tag = '0; enq_src2_tag = '0; enq_dst_tag = '0;
        enq_src1_rdy = 1'b0; enq_src2_rdy = 1'b0; wb_valid = '0; wb_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        mq.delete();
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        chk("rst_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // One clock: drive inputs, check against the model, predict the next state.
    task automatic cycle(input bit fl, input bit ev, input logic [DW-1:0] d,
                         input logic [TW-1:0] t1, input bit r1,
                         input logic [TW-1:0] t2, input bit r2,
                         input logic [TW-1:0] dt, input logic [NWB-1:0] wv,
                         input logic [NWB*TW-1:0] wt, input bit ir);
        int   sel;
        int   n;
        ent_t e;
        flush = fl; enq_valid = ev; enq_data = d;
        enq_src1_tag = t1; enq_src1_rdy = r1; enq_src2_tag = t2; enq_src2_rdy = r2;
        enq_dst_tag = dt; wb_valid = wv; wb_tag = wt; iss_ready = ir;
        #1;
        n = mq.size();
        chk("count", 64'(count), 64'(n));
        chk("full", 64'(full), 64'(n == DEPTH));
        chk("empty", 64'(empty), 64'(n == 0));
        chk("enq_ready", 64'(enq_ready), 64'(n != DEPTH));
        sel = -1;
        for (int i = 0; i < n; i++)
            if (sel < 0 && eligible(mq[i])) sel = i;
        chk("iss_valid", 64'(iss_valid), 64'(sel >= 0));
        if (sel < 0) chk("idle_outputs", 64'({iss_dst_tag, iss_data}), 64'd0);
        else if (ir) exp_q.push_back(iss_t'{mq[sel].data, mq[sel].dst});

        if (fl) begin
            mq.delete();
        end else begin
            if (sel >= 0 && ir) mq.delete(sel);
            if (ev && n < DEPTH) begin
                e.data = d; e.s1t = t1; e.s1r = r1; e.s2t = t2; e.s2r = r2; e.dst = dt;
                mq.push_back(e);
            end
            foreach (mq[i]) begin
                if (wb_hit(mq[i].s1t)) mq[i].s1r = 1'b1;
                if (wb_hit(mq[i].s2t)) mq[i].s2r = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ir);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 1, '0, 1, '0, '0, '0, ir);
    endtask

    task automatic rand_phase(input int n, input int p_enq, input int p_iss);
        for (int i = 0; i < n; i++)
            cycle($urandom_range(0, 99) < 1, $urandom_range(0, 99) < p_enq, $urandom,
                  TW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                  TW'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
                  TW'($urandom), NWB'($urandom),
                  {TW'($urandom_range(0, 7)), TW'($urandom_range(0, 7))},
                  $urandom_range(0, 99) < p_iss);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Three ready entries, then drain in order.
        for (int i = 0; i < 3; i++) cycle(0, 1, 32'h100 + i, 6'd1, 1, 6'd2, 1, TW'(i + 1), '0, '0, 0);
        idle(5, 1);

        // Fill with entries waiting on tag 5, overfill, then wake on channel 0.
        for (int i = 0; i < 17; i++) cycle(0, 1, 32'h200 + i, 6'd5, 0, 6'd3, 1, TW'(i), '0, '0, 1);
        idle(1, 1);
        cycle(0, 0, '0, '0, 1, '0, 1, '0, 2'b01, {6'd0, 6'd5}, 1);
        idle(18, 1);

        // Two waiters on tag 7 ahead of a ready entry 0xABCD.
        for (int i = 0; i < 2; i++) cycle(0, 1, 32'h300 + i, 6'd7, 0, 6'd7, 1, TW'(i), '0, '0, 0);
        cycle(0, 1, 32'hABCD, 6'd1, 1, 6'd1, 1, 6'd33, '0, '0, 0);
        idle(2, 1);
        cycle(0, 0, '0, '0, 1, '0, 1, '0, 2'b10, {6'd7, 6'd0}, 0);
        idle(3, 1);

        // count=4, simultaneous enq and issue; enqueued tag 9 woken by channel 1.
        for (int i = 0; i < 4; i++) cycle(0, 1, 32'h400 + i, 6'd1, 1, 6'd1, 1, TW'(i), '0, '0, 0);
        cycle(0, 1, 32'h4FF, 6'd9, 0, 6'd9, 0, 6'd44, 2'b10, {6'd9, 6'd0}, 1);
        idle(6, 1);

        // count=10 then flush together with an enqueue.
        for (int i = 0; i < 10; i++) cycle(0, 1, 32'h500 + i, 6'd2, 0, 6'd2, 1, TW'(i), '0, '0, 0);
        cycle(1, 1, 32'h5FF, 6'd1, 1, 6'd1, 1, 6'd55, '0, '0, 0);
        idle(2, 1);

        rand_phase(600, 85, 35);
        rand_phase(600, 35, 85);
        do_reset();
        rand_phase(400, 60, 60);

        idle(1, 0);
        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
